// File: rtl/err_inj_pkg.sv
// Shared types and helpers for the Hamming-path error injector.
// Holds the mode/trigger/state encodings, the LFSR polynomial and position reduction.
package err_inj_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_SINGLE = 2'd1,
    MODE_DOUBLE = 2'd2,
    MODE_RANDOM = 2'd3
  } mode_e;

  // Encoding 3 behaves exactly like continuous triggering.
  typedef enum logic [1:0] {
    TRIG_ONESHOT  = 2'd0,
    TRIG_PERIODIC = 2'd1,
    TRIG_CONT     = 2'd2,
    TRIG_CONT_ALT = 2'd3
  } trig_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  function automatic int unsigned reducePos(input int unsigned pos, input int unsigned width);
    return pos % width;
  endfunction

endpackage

// File: rtl/err_inj_ch.sv
// One injector channel: trigger FSM, period counter, Galois LFSR, flip-mask
// generation and the registered output stage.
module err_inj_ch
  import err_inj_pkg::*;
#(
  parameter int          DATA_W = 16,
  parameter int          CNT_W  = 16,
  parameter logic [31:0] SEED   = 32'hACE1_0001,
  localparam int         PW     = $clog2(DATA_W)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cfg_we,
  input  logic [1:0]        i_cfg_mode,
  input  logic [1:0]        i_cfg_trig,
  input  logic [PW-1:0]     i_cfg_pos0,
  input  logic [PW-1:0]     i_cfg_pos1,
  input  logic [CNT_W-1:0]  i_cfg_period,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_err_inj,
  output logic              o_dbit_err,
  output logic              o_armed,
  output logic [CNT_W-1:0]  o_inj_cnt
);

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  trig_e             trig_q, trig_d;
  logic [PW-1:0]     pos0_q, pos0_d;
  logic [PW-1:0]     pos1_q, pos1_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic [CNT_W-1:0]  beatCnt_q, beatCnt_d;
  logic [31:0]       lfsr_q, lfsr_d;
  logic [CNT_W-1:0]  injCnt_q, injCnt_d;
  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic              errInj_q;
  logic              dbit_q;

  logic [PW-1:0]     selP0, selP1Raw, selP1;
  logic              useDouble;
  logic [DATA_W-1:0] flipMask;
  logic [CNT_W-1:0]  lastBeat;
  logic              periodHit;
  logic              trigHit;
  logic              fire;

  // Flip positions come from the fixed config or from the LFSR in RANDOM mode;
  // a colliding second position moves up by one so a double flip is always two bits.
  always_comb begin
    selP0     = PW'(reducePos(32'(pos0_q), unsigned'(DATA_W)));
    selP1Raw  = PW'(reducePos(32'(pos1_q), unsigned'(DATA_W)));
    useDouble = (mode_q == MODE_DOUBLE);
    if (mode_q == MODE_RANDOM) begin
      selP0     = PW'(reducePos(32'(lfsr_q[8:1]), unsigned'(DATA_W)));
      selP1Raw  = PW'(reducePos(32'(lfsr_q[16:9]), unsigned'(DATA_W)));
      useDouble = lfsr_q[0];
    end
    selP1 = (selP1Raw == selP0) ? PW'(reducePos(32'(selP0) + 32'd1, unsigned'(DATA_W)))
                                : selP1Raw;
    flipMask        = '0;
    flipMask[selP0] = 1'b1;
    if (useDouble) flipMask[selP1] = 1'b1;
  end

  always_comb begin
    lastBeat  = (period_q == '0) ? '0 : period_q - 1'b1;
    periodHit = (beatCnt_q == lastBeat);
    case (trig_q)
      TRIG_ONESHOT:  trigHit = 1'b1;
      TRIG_PERIODIC: trigHit = periodHit;
      default:       trigHit = 1'b1;
    endcase
    fire = i_valid && (state_q == ST_ARMED) && (mode_q != MODE_OFF) && trigHit;

    state_d   = state_q;
    mode_d    = mode_q;
    trig_d    = trig_q;
    pos0_d    = pos0_q;
    pos1_d    = pos1_q;
    period_d  = period_q;
    beatCnt_d = beatCnt_q;
    lfsr_d    = i_valid ? ((lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_POLY : 32'h0)) : lfsr_q;
    injCnt_d  = (fire && (injCnt_q != '1)) ? injCnt_q + 1'b1 : injCnt_q;

    if (i_valid && (state_q == ST_ARMED) && (trig_q == TRIG_PERIODIC))
      beatCnt_d = periodHit ? '0 : beatCnt_q + 1'b1;
    if (fire && (trig_q == TRIG_ONESHOT))
      state_d = ST_DONE;

    // A config write overrides the beat's state update; the beat itself already
    // used the old settings above.
    if (i_cfg_we) begin
      mode_d    = mode_e'(i_cfg_mode);
      trig_d    = trig_e'(i_cfg_trig);
      pos0_d    = i_cfg_pos0;
      pos1_d    = i_cfg_pos1;
      period_d  = i_cfg_period;
      beatCnt_d = '0;
      state_d   = (mode_e'(i_cfg_mode) == MODE_OFF) ? ST_IDLE : ST_ARMED;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_OFF;
      trig_q    <= TRIG_ONESHOT;
      pos0_q    <= '0;
      pos1_q    <= '0;
      period_q  <= '0;
      beatCnt_q <= '0;
      lfsr_q    <= SEED;
      injCnt_q  <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      errInj_q  <= 1'b0;
      dbit_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      trig_q    <= trig_d;
      pos0_q    <= pos0_d;
      pos1_q    <= pos1_d;
      period_q  <= period_d;
      beatCnt_q <= beatCnt_d;
      lfsr_q    <= lfsr_d;
      injCnt_q  <= injCnt_d;
      valid_q   <= i_valid;
      data_q    <= fire ? (i_data ^ flipMask) : i_data;
      errInj_q  <= fire;
      dbit_q    <= fire && useDouble;
    end
  end

  assign o_valid    = valid_q;
  assign o_data     = data_q;
  assign o_err_inj  = errInj_q;
  assign o_dbit_err = dbit_q;
  assign o_armed    = (state_q == ST_ARMED);
  assign o_inj_cnt  = injCnt_q;

endmodule

// File: rtl/err_inj_ctrl.sv
// Multi-channel error injector: one err_inj_ch per memory port, with the
// config bus decoded into per-channel write strobes.
module err_inj_ctrl
  import err_inj_pkg::*;
#(
  parameter int          DATA_W    = 16,
  parameter int          NUM_CH    = 2,
  parameter int          CNT_W     = 16,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_0001,
  localparam int         CHW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int         PW        = $clog2(DATA_W)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_cfg_we,
  input  logic [CHW-1:0]           i_cfg_ch,
  input  logic [1:0]               i_cfg_mode,
  input  logic [1:0]               i_cfg_trig,
  input  logic [PW-1:0]            i_cfg_pos0,
  input  logic [PW-1:0]            i_cfg_pos1,
  input  logic [CNT_W-1:0]         i_cfg_period,
  input  logic [NUM_CH-1:0]        i_valid,
  input  logic [NUM_CH*DATA_W-1:0] i_data,
  output logic [NUM_CH-1:0]        o_valid,
  output logic [NUM_CH*DATA_W-1:0] o_data,
  output logic [NUM_CH-1:0]        o_err_inj,
  output logic [NUM_CH-1:0]        o_dbit_err,
  output logic [NUM_CH-1:0]        o_armed,
  output logic [NUM_CH*CNT_W-1:0]  o_inj_cnt
);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    err_inj_ch #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W),
      .SEED   (LFSR_SEED ^ 32'(k))
    ) u_ch (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_cfg_we     (i_cfg_we && (i_cfg_ch == CHW'(k))),
      .i_cfg_mode   (i_cfg_mode),
      .i_cfg_trig   (i_cfg_trig),
      .i_cfg_pos0   (i_cfg_pos0),
      .i_cfg_pos1   (i_cfg_pos1),
      .i_cfg_period (i_cfg_period),
      .i_valid      (i_valid[k]),
      .i_data       (i_data[k*DATA_W +: DATA_W]),
      .o_valid      (o_valid[k]),
      .o_data       (o_data[k*DATA_W +: DATA_W]),
      .o_err_inj    (o_err_inj[k]),
      .o_dbit_err   (o_dbit_err[k]),
      .o_armed      (o_armed[k]),
      .o_inj_cnt    (o_inj_cnt[k*CNT_W +: CNT_W])
    );
  end

endmodule
